// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants: opcodes, instruction formats, immediate bounds.
// Used by both the decode-side immediate generator and the encoder.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    FMT_R = 2'b00,
    FMT_I = 2'b01,
    FMT_S = 2'b10,
    FMT_B = 2'b11
  } fmt_e;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// A pop does not free space for a push in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_cnt_nxt;

  assign w_push = push & !r_full;
  assign w_pop  = pop & !r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push & !w_pop)
      w_cnt_nxt = r_cnt + ONE_CNT;
    else if (!w_push & w_pop)
      w_cnt_nxt = r_cnt - ONE_CNT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == FULL_CNT);
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  assign rdata = r_mem[r_rptr];
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/instr_encoder.sv
// Streaming R/I/S/B instruction encoder: packs fields, range-checks immediates,
// and writes accepted words to instruction memory at an auto-incrementing address.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              ld_addr,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err_range,
  output logic [7:0]        err_count,
  output logic              busy
);

  logic              r_stage_v;
  logic              r_stage_err;
  logic [31:0]       r_stage_word;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err_range;
  logic [7:0]        r_err_count;

  logic        w_hs;
  logic        w_stage_go;
  logic        w_push;
  logic        w_drop;
  logic        w_wr_done;
  logic        w_full;
  logic        w_empty;
  logic [31:0] w_head;
  logic        w_fmt_ok;
  logic        w_imm_ok;
  logic [31:0] w_word;
  logic        w_imm12_ok;
  logic        w_imm13_ok;
  logic        w_unused;

  assign w_unused = ^base_addr[1:0];

  assign w_imm12_ok = ($signed(in_imm) >= IMM12_MIN) &&
                      ($signed(in_imm) <= IMM12_MAX);
  assign w_imm13_ok = ($signed(in_imm) >= IMM13_MIN) &&
                      ($signed(in_imm) <= IMM13_MAX) &&
                      !in_imm[0];

  always_comb begin
    w_fmt_ok = 1'b0;
    w_imm_ok = 1'b1;
    w_word   = '0;
    unique case (fmt_e'(in_fmt))
      FMT_R: begin
        w_fmt_ok = (in_opcode == OP_OP);
        w_word   = {in_funct7, in_rs2, in_rs1, in_funct3,
                    in_rd, in_opcode};
      end
      FMT_I: begin
        w_fmt_ok = (in_opcode == OP_LOAD) ||
                   (in_opcode == OP_IMM);
        w_imm_ok = w_imm12_ok;
        w_word   = {in_imm[11:0], in_rs1, in_funct3,
                    in_rd, in_opcode};
      end
      FMT_S: begin
        w_fmt_ok = (in_opcode == OP_STORE);
        w_imm_ok = w_imm12_ok;
        w_word   = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:0], in_opcode};
      end
      FMT_B: begin
        w_fmt_ok = (in_opcode == OP_BRANCH);
        w_imm_ok = w_imm13_ok;
        w_word   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                    in_funct3, in_imm[4:1], in_imm[11], in_opcode};
      end
      default: ;
    endcase
  end

  // Uses the registered full flag only: no mem_ready -> in_ready path.
  assign in_ready   = rst_n & (!r_stage_v | r_stage_err | !w_full);
  assign w_hs       = in_valid & in_ready;
  assign w_stage_go = r_stage_v & (r_stage_err | !w_full);
  assign w_push     = r_stage_v & !r_stage_err & !w_full;
  assign w_drop     = r_stage_v & r_stage_err;
  assign w_wr_done  = !w_empty & mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_v    <= 1'b0;
      r_stage_err  <= 1'b0;
      r_stage_word <= '0;
    end else if (w_hs) begin
      r_stage_v    <= 1'b1;
      r_stage_err  <= !(w_fmt_ok & w_imm_ok);
      r_stage_word <= w_word;
    end else if (w_stage_go) begin
      r_stage_v    <= 1'b0;
      r_stage_err  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_range <= 1'b0;
      r_err_count <= '0;
    end else if (w_drop) begin
      r_err_range <= 1'b1;
      if (r_err_count != 8'hFF)
        r_err_count <= r_err_count + 8'd1;
    end
  end

  // A load wins over the advance of a write completing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_addr <= '0;
    else if (ld_addr)
      r_addr <= {base_addr[ADDR_W-1:2], 2'b00};
    else if (w_wr_done)
      r_addr <= r_addr + ADDR_W'(4);
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (r_stage_word),
    .pop   (w_wr_done),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign mem_we    = !w_empty;
  assign mem_wdata = w_head & {32{!w_empty}};
  assign mem_addr  = r_addr;
  assign err_range = r_err_range;
  assign err_count = r_err_count;
  assign busy      = r_stage_v | !w_empty;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
// Writes are captured by a monitor and compared against hand-computed words.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        ld_addr;
  logic [11:0] base_addr;
  logic        mem_we;
  logic        mem_ready;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        err_range;
  logic [7:0]  err_count;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [43:0] wq[$];

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(12), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .ld_addr(ld_addr), .base_addr(base_addr),
    .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .err_range(err_range), .err_count(err_count), .busy(busy)
  );

  always @(posedge clk)
    if (rst_n && mem_we && mem_ready)
      wq.push_back({mem_addr, mem_wdata});

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx,
                          input logic [11:0] a, input logic [31:0] d);
    logic [43:0] e;
    e = 44'h0;
    if (idx < wq.size()) e = wq[idx];
    check({tag, "_addr"}, {20'h0, e[43:32]}, {20'h0, a});
    check({tag, "_data"}, e[31:0], d);
  endtask

  task automatic set_fields(input logic [1:0] f, input logic [6:0] op,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // Called just after a negedge; returns just after the next negedge.
  task automatic send(input logic [1:0] f, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    logic r;
    int t;
    set_fields(f, op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    t = 0;
    r = in_ready;
    while (!r && t < 50) begin
      @(negedge clk);
      r = in_ready;
      t++;
    end
    if (!r) begin
      n_checks++;
      n_errors++;
      $error("FAIL send_timeout observed=0 expected=1");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    assert (!busy) else begin
      n_errors++;
      $error("FAIL drain_timeout observed=%b expected=0", busy);
    end
    @(negedge clk);
  endtask

  task automatic load(input logic [11:0] b);
    ld_addr = 1'b1;
    base_addr = b;
    @(negedge clk);
    ld_addr = 1'b0;
  endtask

  initial begin
    int acc;
    int t;
    logic [31:0] hold_d;
    logic [11:0] hold_a;

    rst_n = 1'b0;
    in_valid = 1'b0;
    ld_addr = 1'b0;
    base_addr = '0;
    mem_ready = 1'b1;
    set_fields(2'b00, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'h0, in_ready}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_err_count", {24'h0, err_count}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

    // addi x1,x0,-1 at 0x100
    load(12'h100);
    send(2'b01, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    drain();
    check("addi_count", wq.size(), 1);
    check_wr("addi", 0, 12'h100, 32'hFFF00093);
    wq.delete();

    // sw, beq, add
    load(12'h100);
    send(2'b10, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    send(2'b11, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    send(2'b00, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
    drain();
    check("sbr_count", wq.size(), 3);
    check_wr("sw", 0, 12'h100, 32'h0020A423);
    check_wr("beq", 1, 12'h104, 32'hFE208EE3);
    check_wr("add", 2, 12'h108, 32'h002081B3);
    wq.delete();

    // error drops
    send(2'b01, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send(2'b11, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    send(2'b10, 7'b0010011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd0);
    drain();
    check("err_writes", wq.size(), 0);
    check("err_range", {31'h0, err_range}, 32'h1);
    check("err_count", {24'h0, err_count}, 32'd3);
    check("err_addr", {20'h0, mem_addr}, 32'h10C);
    send(2'b01, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    drain();
    check_wr("after_err", 0, 12'h10C, 32'hFFF00093);
    wq.delete();

    // backpressure: addi xk,x0,k for k=1..5
    load(12'h200);
    mem_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      set_fields(2'b01, 7'b0010011, 5'(acc + 1), 5'd0, 5'd0, 3'd0,
                 7'd0, 32'(acc + 1));
      in_valid = 1'b1;
      if (in_ready) acc++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 3);
    check("bp_in_ready", {31'h0, in_ready}, 32'h0);
    hold_d = mem_wdata;
    hold_a = mem_addr;
    repeat (3) @(negedge clk);
    check("bp_hold_data", mem_wdata, hold_d);
    check("bp_hold_addr", {20'h0, mem_addr}, {20'h0, hold_a});
    check("bp_head", mem_wdata, 32'h00100093);
    mem_ready = 1'b1;
    t = 0;
    while (acc < 5 && t < 50) begin
      set_fields(2'b01, 7'b0010011, 5'(acc + 1), 5'd0, 5'd0, 3'd0,
                 7'd0, 32'(acc + 1));
      in_valid = 1'b1;
      if (in_ready) acc++;
      @(posedge clk);
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    drain();
    check("bp_count", wq.size(), 5);
    check_wr("bp0", 0, 12'h200, 32'h00100093);
    check_wr("bp1", 1, 12'h204, 32'h00200113);
    check_wr("bp2", 2, 12'h208, 32'h00300193);
    check_wr("bp3", 3, 12'h20C, 32'h00400213);
    check_wr("bp4", 4, 12'h210, 32'h00500293);
    wq.delete();

    // address wrap
    load(12'hFFC);
    send(2'b01, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    send(2'b01, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    drain();
    check_wr("wrap0", 0, 12'hFFC, 32'h00100093);
    check_wr("wrap1", 1, 12'h000, 32'h00200113);
    wq.delete();

    // ld_addr coincident with a completing write
    mem_ready = 1'b0;
    send(2'b01, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    send(2'b01, 7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
    @(negedge clk);
    ld_addr = 1'b1;
    base_addr = 12'h203;
    mem_ready = 1'b1;
    @(negedge clk);
    ld_addr = 1'b0;
    drain();
    check_wr("ld_old", 0, 12'h004, 32'h00300193);
    check_wr("ld_new", 1, 12'h200, 32'h00400213);
    wq.delete();

    // reset mid-stream
    mem_ready = 1'b0;
    send(2'b01, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    send(2'b01, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    send(2'b01, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("mid_rst_wdata", mem_wdata, 32'h0);
    check("mid_rst_addr", {20'h0, mem_addr}, 32'h0);
    check("mid_rst_err", {23'h0, err_range, err_count}, 32'h0);
    check("mid_rst_ready_busy", {30'h0, in_ready, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_writes", wq.size(), 0);
    check("post_rst_err_count", {24'h0, err_count}, 32'h0);
    check("post_rst_ready", {31'h0, in_ready}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RISC-V instruction encoder. It takes decoded instruction fields over a valid/ready handshake and packs R/I/S/B-format words. It range-checks each immediate against its format and writes accepted words to instruction memory at an auto-incrementing byte address. It is the inverse of the core's immediate/field decode path: the boot loader and self-test sequencer use it to emit programs into instruction RAM, so that decoding any written word recovers the original fields.

## Interface
- ADDR_W, 12: instruction-memory byte-address width.
- DEPTH, 2: output FIFO entries (power of two, ≥2).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept this cycle.
- in_fmt  in  2  00=R, 01=I, 10=S, 11=B.
- in_opcode  in  7  opcode field.
- in_rd, in_rs1, in_rs2  in  5 each  register fields; unused fields are ignored.
- in_funct3  in  3; in_funct7  in  7 (R only).
- in_imm  in  32  signed immediate, byte offset for B.
- ld_addr  in  1  load write address from base_addr.
- base_addr  in  ADDR_W  new write address.
- mem_we  out  1  write request (valid).
- mem_ready  in  1  memory accepts write this cycle.
- mem_addr  out  ADDR_W  byte address, word-aligned.
- mem_wdata  out  32  encoded instruction.
- err_range  out  1  sticky: an immediate was out of range, misaligned, or had a fmt/opcode mismatch.
- err_count  out  8  dropped bundles, saturating at 255.
- busy  out  1  stage or FIFO occupied.

## Operation
- Legal opcodes per format:
  - R: 0110011.
  - I: 0000011, 0010011.
  - S: 0100011.
  - B: 1100011.
  - Any other fmt/opcode pair is a format error.
- Immediate checks:
  - I and S: in_imm must lie in −2048..2047.
  - B: in_imm must lie in −4096..4094 and be even.
  - R: in_imm is ignored.
- Packing:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Pipeline:
  - Handshake (in_valid & in_ready) registers the encoded word and its error bit into a one-entry encode stage.
  - Next edge: a good entry pushes into the FIFO. An erroring entry is dropped: err_range is set, err_count increments (saturating), and nothing is written.
- Memory port:
  - mem_we = FIFO non-empty. mem_wdata is the FIFO head.
  - A write completes on mem_we & mem_ready. The FIFO pops and the address counter advances by 4, wrapping modulo 2^ADDR_W.
- ld_addr:
  - Sets the address counter to {base_addr[ADDR_W-1:2], 2'b00} at the next edge.
  - If ld_addr coincides with a completing write, that write uses the old address and ld_addr wins for the next address.
- in_ready = rst_n & (!stage_v | stage_err | !fifo_full).
  - fifo_full is the registered full flag. A same-cycle pop does not free space for a push; there is no combinational path from mem_ready to in_ready.
- Reset: every output is 0 (in_ready 0 while rst_n is low), address counter 0, FIFO and stage emptied, err_range 0, err_count 0.
  - Reset mid-stream discards all pending words; none are written after release.
- mem_wdata and mem_addr must hold stable while mem_we & !mem_ready.

## Timing
- Handshake at edge N → stage valid after N; FIFO push at N+1; mem_we high from N+1 (minimum latency 2 edges to a write).
- Throughput: 1 word/cycle with mem_ready held high.
- Capacity under stall: 1 + DEPTH bundles accepted before in_ready drops.
- err_range and err_count update at edge N+1 for a bundle handshaken at N.
- busy = stage_v | !fifo_empty, all registered state.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_OP;
  - fmt enum FMT_R/I/S/B;
  - immediate bound constants.
  - The decode-side immediate generator and this block both use it.
- Sub-module sync_fifo (WIDTH=32, DEPTH) provides registered full/empty flags. Encode, check and address logic stay in instr_encoder.

## Test plan
- I, addi x1,x0,−1 (opcode 0010011, rd=1, imm=0xFFFFFFFF) after ld_addr base 0x100 → one write, addr 0x100, data 0xFFF00093.
- S, sw x2,8(x1) then B, beq x1,x2,−4, then R, add x3,x1,x2 → data 0x0020A423 @0x100, 0xFE208EE3 @0x104, 0x002081B3 @0x108.
- Errors: I imm=2048, B imm=3, fmt=S with opcode 0010011 → no writes, err_range=1, err_count=3, address unchanged. Then a good word → written at the unchanged address.
- Backpressure, DEPTH=2, mem_ready=0, stream 5 bundles → exactly 3 accepted, and mem_wdata/mem_addr stay stable. Release mem_ready → words written in order at base, +4, +8, then the remaining 2.
- Wrap and load: ADDR_W=12, base 0xFFC, two words → addresses 0xFFC then 0x000. ld_addr 0x200 coincident with a write → that write at the old address, next at 0x200.
- Reset asserted with 3 words pending → all outputs 0 immediately. After release: no stale writes, err_count=0, in_ready=1.
